key_entry: RTL and testbench
============================

Name: key_entry

Overview:
- Input front-end stage that sits directly upstream of the 8-digit nibble shift register.
- Conditions the raw board inputs: 4 slide switches and one active-low ENTER push button.
- Outputs a debounced 4-bit data value plus a single-cycle LOAD strobe per accepted key press. The shift stage uses LOAD as its shift-enable instead of a free-running timer.
- Also drives status LEDs so the operator can see accepted data and key state.

Parameters:
- DEB_CNT, 1000000, consecutive stable cycles required to accept an input change (20 ms at 50 MHz).
- REP_DLY, 25000000, cycles ENTER must be held before the first auto-repeat (0.5 s).
- REP_PER, 10000000, cycles between subsequent auto-repeats (0.2 s).
- CW, 25, width of the internal counters; must satisfy 2^CW > max(DEB_CNT, REP_DLY, REP_PER).

Ports:
- CLK, input, 1, 50 MHz system clock.
- RST_N, input, 1, reset.
- SW, input, 4, raw asynchronous slide-switch data.
- KEY_N, input, 1, raw asynchronous ENTER button, 0 = pressed.
- D_OUT, output, 4, debounced switch value.
- LOAD, output, 1, one-cycle strobe; downstream samples D_OUT on a cycle where LOAD=1.
- LED_KEY, output, 1, high while the FSM is in PRESSED or REPEAT.
- LED_D, output, 4, mirror of D_OUT.

Behaviour:
- Reset: RST_N, synchronous, active-low; clock CLK.
- Reset values:
  - D_OUT = 4'h0, LOAD = 0, LED_KEY = 0.
  - FSM = IDLE, all counters = 0.
  - Synchronizer flops: SW stages = 0, KEY_N stages = 1.
- Synchronizers: SW and KEY_N each pass through a 2-flop synchronizer. All logic below uses only the synchronized values (sw_s, key_s).
- Switch debounce (independent of the FSM):
  - If sw_s == D_OUT, the switch counter is cleared.
  - Otherwise it increments. If sw_s changes value while counting, the counter restarts from 0.
  - When the counter reaches DEB_CNT-1, D_OUT <= sw_s on the next edge and the counter clears.
  - Total latency from a stable raw change to D_OUT = 2 sync cycles + DEB_CNT cycles.
- Key FSM (one counter, kcnt):
  - IDLE: if key_s=0, go to DEB_P with kcnt=0.
  - DEB_P: if key_s=1, return to IDLE. If key_s=0 and kcnt==DEB_CNT-1, go to PRESSED, assert LOAD for exactly one cycle, kcnt=0. Otherwise kcnt++.
  - PRESSED: if key_s=1, go to DEB_R with kcnt=0. Otherwise hold (see Optional Feature).
  - DEB_R: if key_s=0, return to PRESSED with kcnt=0 and no LOAD. If key_s=1 and kcnt==DEB_CNT-1, go to IDLE. Otherwise kcnt++.
  - REPEAT: exists only with the optional feature.
- Exactly one LOAD per accepted press. No LOAD on release or on release bounce.
- Simultaneous switch acceptance and LOAD in the same cycle: LOAD accompanies the old D_OUT. The new value is visible from the next cycle.
- Reset asserted mid-press: FSM returns to IDLE and no LOAD is issued. A key still held after reset must be re-debounced through DEB_P, which produces a new LOAD.
- Counters never wrap; they saturate logically because every compare terminates before overflow.

Optional Feature:
- Macro: KEY_AUTO_REPEAT_EN.
- Defined:
  - In PRESSED, kcnt counts while key_s=0. At REP_DLY-1, go to REPEAT, pulse LOAD, kcnt=0.
  - In REPEAT, pulse LOAD every REP_PER cycles while held. key_s=1 goes to DEB_R.
- Undefined: the REPEAT state and its comparators are absent, and PRESSED simply holds.

Test Plan (DEB_CNT=4, REP_DLY=20, REP_PER=8):
- Reset with SW=4'hA, KEY_N=1 → D_OUT=0 and LOAD=0 during reset. D_OUT=4'hA exactly 2+4 cycles after RST_N deasserts.
- SW toggles 4'h3/4'h5 every 2 cycles for 20 cycles, then settles at 4'h5 → D_OUT does not change until 6 cycles after settling, then reads 4'h5.
- KEY_N low for 3 cycles then high (bounce) → no LOAD. KEY_N low for 10 cycles → exactly one LOAD, 6 cycles after the fall, with D_OUT sampled correctly.
- Held press released with 2-cycle glitches → no extra LOAD. FSM reaches IDLE 6 cycles after a clean release.
- RST_N pulsed low while in DEB_P, key still held → no LOAD before reset. One LOAD 6 cycles after reset release.
- KEY_AUTO_REPEAT_EN defined, KEY_N held 60 cycles → LOADs at t=6, 26, 34, 42, 50, 58 (first press, then repeats). Without the macro → single LOAD at t=6.

Source files
------------

// File: rtl/key_entry.sv
// Key entry front-end: synchronizes switches and ENTER, debounces both, emits one LOAD per press.
// Optional auto-repeat while ENTER is held is enabled by defining KEY_AUTO_REPEAT_EN.
module key_entry #(
  parameter int DEB_CNT = 1000000,
  parameter int REP_DLY = 25000000,
  parameter int REP_PER = 10000000,
  parameter int CW      = 25
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [3:0] SW,
  input  logic       KEY_N,
  output logic [3:0] D_OUT,
  output logic       LOAD,
  output logic       LED_KEY,
  output logic [3:0] LED_D
);

  if ((DEB_CNT < 1) || (REP_DLY < 1) || (REP_PER < 1) || (CW < 1) || (CW > 31) ||
      ((DEB_CNT >> CW) != 0) || ((REP_DLY >> CW) != 0) || ((REP_PER >> CW) != 0)) begin : g_bad_cfg
    $error("key_entry: CW too small for the configured delays");
  end

  localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CNT - 1);
`ifdef KEY_AUTO_REPEAT_EN
  localparam logic [CW-1:0] DLY_LAST = CW'(REP_DLY - 1);
  localparam logic [CW-1:0] PER_LAST = CW'(REP_PER - 1);
  typedef enum logic [2:0] {IDLE, DEB_P, PRESSED, DEB_R, REPEAT} state_t;
`else
  typedef enum logic [2:0] {IDLE, DEB_P, PRESSED, DEB_R} state_t;
`endif

  logic [3:0]    sw_m, sw_s;
  logic          key_m, key_s;
  logic [CW-1:0] scnt;
  logic [CW-1:0] kcnt, kcnt_nx;
  state_t        state, state_nx;
  logic          load_c;

  // Stage: two-flop synchronizers; ENTER idles high so its flops reset to 1
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      sw_m  <= 4'h0;
      sw_s  <= 4'h0;
      key_m <= 1'b1;
      key_s <= 1'b1;
    end else begin
      sw_m  <= SW;
      sw_s  <= sw_m;
      key_m <= KEY_N;
      key_s <= key_m;
    end
  end

  // Stage: switch debounce; sw_m != sw_s means sw_s changes on this edge, so restart the count
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      D_OUT <= 4'h0;
      scnt  <= '0;
    end else if (sw_s == D_OUT) begin
      scnt <= '0;
    end else if (scnt == DEB_LAST) begin
      D_OUT <= sw_s;
      scnt  <= '0;
    end else if (sw_m != sw_s) begin
      scnt <= '0;
    end else begin
      scnt <= scnt + CW'(1);
    end
  end

  // Stage: key FSM state register
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state <= IDLE;
      kcnt  <= '0;
    end else begin
      state <= state_nx;
      kcnt  <= kcnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    kcnt_nx  = kcnt;
    load_c   = 1'b0;
    case (state)
      IDLE: begin
        kcnt_nx = '0;
        if (!key_s) state_nx = DEB_P;
      end
      DEB_P: begin
        if (key_s) begin
          state_nx = IDLE;
          kcnt_nx  = '0;
        end else if (kcnt == DEB_LAST) begin
          state_nx = PRESSED;
          kcnt_nx  = '0;
          load_c   = 1'b1;
        end else begin
          kcnt_nx = kcnt + CW'(1);
        end
      end
      PRESSED: begin
        if (key_s) begin
          state_nx = DEB_R;
          kcnt_nx  = '0;
        end
`ifdef KEY_AUTO_REPEAT_EN
        else if (kcnt == DLY_LAST) begin
          state_nx = REPEAT;
          kcnt_nx  = '0;
          load_c   = 1'b1;
        end else begin
          kcnt_nx = kcnt + CW'(1);
        end
`endif
      end
      DEB_R: begin
        if (!key_s) begin
          state_nx = PRESSED;
          kcnt_nx  = '0;
        end else if (kcnt == DEB_LAST) begin
          state_nx = IDLE;
          kcnt_nx  = '0;
        end else begin
          kcnt_nx = kcnt + CW'(1);
        end
      end
`ifdef KEY_AUTO_REPEAT_EN
      REPEAT: begin
        if (key_s) begin
          state_nx = DEB_R;
          kcnt_nx  = '0;
        end else if (kcnt == PER_LAST) begin
          kcnt_nx = '0;
          load_c  = 1'b1;
        end else begin
          kcnt_nx = kcnt + CW'(1);
        end
      end
`endif
      default: begin
        state_nx = IDLE;
        kcnt_nx  = '0;
      end
    endcase
  end

  // LOAD is the transition strobe, so it pairs with the D_OUT value present in that same cycle
  assign LOAD = load_c & RST_N;
`ifdef KEY_AUTO_REPEAT_EN
  assign LED_KEY = (state == PRESSED) || (state == REPEAT);
`else
  assign LED_KEY = (state == PRESSED);
`endif
  assign LED_D = D_OUT;

endmodule

// File: tb/tb_key_entry.sv
// Self-checking bench for key_entry (DEB_CNT=4, REP_DLY=20, REP_PER=8): LOAD events scored
// against a queue of expected {cycle, data}; key press patterns applied from a table.
module tb_key_entry;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic [3:0] SW;
  logic       KEY_N;
  logic [3:0] D_OUT;
  logic       LOAD;
  logic       LED_KEY;
  logic [3:0] LED_D;

  int unsigned cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int unsigned cyc;
    logic [3:0]  d;
  } exp_t;
  exp_t sbq[$];
  exp_t mon_e;

  typedef struct {
    logic [3:0] sw;
    int         low;
    int         high;
    logic       load;
    logic       led;
  } vec_t;
  vec_t vecs[5];

  key_entry #(.DEB_CNT(4), .REP_DLY(20), .REP_PER(8), .CW(8)) dut (
    .CLK(CLK), .RST_N(RST_N), .SW(SW), .KEY_N(KEY_N),
    .D_OUT(D_OUT), .LOAD(LOAD), .LED_KEY(LED_KEY), .LED_D(LED_D)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int unsigned c, input logic [3:0] d);
    exp_t e;
    e.cyc = c;
    e.d   = d;
    sbq.push_back(e);
  endtask

  // Scoreboard: every LOAD must match the queue head in cycle and data
  always @(negedge CLK) begin
    if (sbq.size() > 0 && cyc > sbq[0].cyc) begin
      checks++;
      errors++;
      $display("FAIL load_missing: no LOAD by cycle %0d, required at cycle %0d with data %0h",
               cyc, sbq[0].cyc, sbq[0].d);
      void'(sbq.pop_front());
    end
    if (LOAD === 1'b1) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL load_unexpected: LOAD=1 at cycle %0d, required 0", cyc);
      end else begin
        mon_e = sbq.pop_front();
        if (mon_e.cyc != cyc || mon_e.d !== D_OUT) begin
          errors++;
          $display("FAIL load_match: LOAD at cycle %0d data %0h, required cycle %0d data %0h",
                   cyc, D_OUT, mon_e.cyc, mon_e.d);
        end
      end
    end
  end

  initial begin
    int unsigned n;
    vecs[0] = '{sw: 4'h1, low: 10, high: 10, load: 1'b1, led: 1'b1};
    vecs[1] = '{sw: 4'h2, low: 3,  high: 10, load: 1'b0, led: 1'b0};
    vecs[2] = '{sw: 4'h7, low: 5,  high: 10, load: 1'b1, led: 1'b0};
    vecs[3] = '{sw: 4'h8, low: 4,  high: 10, load: 1'b0, led: 1'b0};
    vecs[4] = '{sw: 4'hC, low: 12, high: 10, load: 1'b1, led: 1'b1};

    RST_N = 1'b0;
    SW    = 4'hA;
    KEY_N = 1'b1;
    tick(3);
    check("rst_d_out", D_OUT, 4'h0);
    check("rst_load", LOAD, 1'b0);
    check("rst_led_key", LED_KEY, 1'b0);
    RST_N = 1'b1;
    tick(5);
    check("sw_latency_early", D_OUT, 4'h0);
    tick(1);
    check("sw_latency", D_OUT, 4'hA);
    check("led_d", LED_D, 4'hA);

    for (int i = 0; i < 10; i++) begin
      SW = (i % 2 == 0) ? 4'h3 : 4'h5;
      tick(2);
      check("toggle_hold", D_OUT, 4'hA);
    end
    tick(3);
    check("settle_early", D_OUT, 4'hA);
    tick(1);
    check("settle", D_OUT, 4'h5);

    for (int i = 0; i < 5; i++) begin
      SW = vecs[i].sw;
      tick(8);
      check("vec_d_out", D_OUT, vecs[i].sw);
      n = cyc;
      KEY_N = 1'b0;
      if (vecs[i].load) push(n + 6, vecs[i].sw);
      tick(vecs[i].low);
      check("vec_led_key_held", LED_KEY, vecs[i].led);
      KEY_N = 1'b1;
      tick(vecs[i].high);
      check("vec_led_key_rel", LED_KEY, 1'b0);
    end

    // Release glitches and a 3-cycle release must not retrigger LOAD
    SW = 4'h6;
    tick(8);
    n = cyc;
    KEY_N = 1'b0;
    push(n + 6, 4'h6);
    tick(10);
    for (int i = 0; i < 2; i++) begin
      KEY_N = 1'b1;
      tick(2);
      KEY_N = 1'b0;
      tick(2);
    end
    tick(4);
    check("glitch_held", LED_KEY, 1'b1);
    KEY_N = 1'b1;
    tick(3);
    KEY_N = 1'b0;
    tick(6);
    check("short_release_held", LED_KEY, 1'b1);
    KEY_N = 1'b1;
    tick(12);
    check("clean_release", LED_KEY, 1'b0);

    // Switch accepted one edge after LOAD: LOAD carries the old value
    SW = 4'hB;
    tick(8);
    n = cyc;
    KEY_N = 1'b0;
    push(n + 6, 4'hB);
    tick(1);
    SW = 4'h4;
    tick(9);
    check("same_cycle_new", D_OUT, 4'h4);
    KEY_N = 1'b1;
    tick(12);

    // Long hold: auto-repeat when enabled, single LOAD otherwise
    SW = 4'hD;
    tick(8);
    n = cyc;
    KEY_N = 1'b0;
    push(n + 6, 4'hD);
`ifdef KEY_AUTO_REPEAT_EN
    for (int k = 0; k < 5; k++) push(n + 26 + 8 * k, 4'hD);
`endif
    tick(60);
    check("long_hold_led", LED_KEY, 1'b1);
    KEY_N = 1'b1;
    tick(14);
    check("long_release_led", LED_KEY, 1'b0);

    // Reset during DEB_P with the key held: one LOAD after re-debounce
    SW = 4'h9;
    tick(8);
    n = cyc;
    KEY_N = 1'b0;
    tick(3);
    RST_N = 1'b0;
    tick(1);
    check("midrst_d_out", D_OUT, 4'h0);
    check("midrst_load", LOAD, 1'b0);
    check("midrst_led_key", LED_KEY, 1'b0);
    RST_N = 1'b1;
    push(n + 10, 4'h9);
    tick(8);
    check("midrst_pressed", LED_KEY, 1'b1);
    KEY_N = 1'b1;
    tick(12);

    tick(2);
    check("scoreboard_empty", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
